// File: rtl/wb_burst_master.sv
// -----------------------------------------------------------------------------
// wb_burst_master
//   Wishbone B4 classic/registered-feedback burst master. It accepts a command
//   (direction, start word address, burst length, byte enables) and runs that
//   many beats on the bus. Write data is pulled one word per beat from a
//   valid/ready stream. Read data is returned one word per beat with no
//   backpressure. Every output comes straight from a flop.
//
//   Optional feature macro: WB_BURST_MASTER_TIMEOUT_EN
//     When defined, a beat that waits TIMEOUT_CYCLES strobe cycles without an
//     ack aborts the command: done and err pulse together and the remaining
//     beats are discarded. When undefined, the master waits for ack forever
//     and err is always 0.
//
// Ports
//   wb_clk_i, wb_rst_i       clock, asynchronous active-low reset
//   cmd_valid/cmd_ready      command handshake
//   cmd_we, cmd_addr,        direction (1 = write), start word address,
//   cmd_bl, cmd_sel          beat count (0 means 1), byte enables
//   wr_valid/wr_ready,       write-data stream
//   wr_data
//   rd_valid, rd_data        read beat return
//   done, err                one-cycle completion pulse, err = timeout abort
//   wb_cyc_o ... wb_cti_o    Wishbone master outputs
//   wb_ack_i, wb_dat_i       Wishbone slave responses
// -----------------------------------------------------------------------------
module wb_burst_master #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 26,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_we,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [7:0]              cmd_bl,
    input  logic [DATA_WIDTH/8-1:0] cmd_sel,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    output logic                    rd_valid,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    done,
    output logic                    err,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [ADDR_WIDTH-1:0]   wb_addr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    output logic [2:0]              wb_cti_o,
    input  logic                    wb_ack_i,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WFETCH = 2'd1,
        S_BUS    = 2'd2
    } state_t;

    // Cycle-type tag for a beat: classic for one-beat commands, incrementing
    // burst for non-final beats, end-of-burst for the last beat.
    function automatic logic [2:0] cti_for(input logic burst, input logic [7:0] beats_left);
        logic [2:0] cti;
        if (!burst) begin
            cti = 3'b000;
        end else if (beats_left == 8'd1) begin
            cti = 3'b111;
        end else begin
            cti = 3'b010;
        end
        return cti;
    endfunction

    state_t                  state_r, state_s;
    logic [7:0]              beats_r, beats_s;
    logic                    burst_r, burst_s;
    logic                    cmd_ready_r, cmd_ready_s;
    logic                    wr_ready_r, wr_ready_s;
    logic                    cyc_r, cyc_s;
    logic                    stb_r, stb_s;
    logic                    we_r, we_s;
    logic [ADDR_WIDTH-1:0]   addr_r, addr_s;
    logic [DATA_WIDTH-1:0]   dat_r, dat_s;
    logic [SEL_WIDTH-1:0]    sel_r, sel_s;
    logic [2:0]              cti_r, cti_s;
    logic                    rd_valid_r, rd_valid_s;
    logic [DATA_WIDTH-1:0]   rd_data_r, rd_data_s;
    logic                    done_r, done_s;
    logic                    err_r, err_s;
    logic                    ack_s;
    logic                    tmo_hit_s;

    // An ack only counts while this master is strobing.
    assign ack_s = wb_ack_i & stb_r;

`ifdef WB_BURST_MASTER_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt_r;

    // Counts strobe cycles of the current beat that went by without an ack.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else if ((state_r == S_BUS) && stb_r && !wb_ack_i) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end else begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end
    end

    // This strobe cycle is the last one allowed; abort unless acked now.
    assign tmo_hit_s = (state_r == S_BUS) && stb_r && !wb_ack_i && (tmo_cnt_r == TMO_LAST);
`else
    assign tmo_hit_s = 1'b0;
`endif

    // Next-state and next-output computation for every registered output.
    always_comb begin
        state_s    = state_r;
        beats_s    = beats_r;
        burst_s    = burst_r;
        cyc_s      = cyc_r;
        stb_s      = stb_r;
        we_s       = we_r;
        addr_s     = addr_r;
        dat_s      = dat_r;
        sel_s      = sel_r;
        cti_s      = cti_r;
        rd_valid_s = 1'b0;
        rd_data_s  = rd_data_r;
        done_s     = 1'b0;
        err_s      = 1'b0;

        case (state_r)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_r) begin
                    beats_s = (cmd_bl == 8'd0) ? 8'd1 : cmd_bl;
                    burst_s = (cmd_bl > 8'd1);
                    we_s    = cmd_we;
                    addr_s  = cmd_addr;
                    sel_s   = cmd_sel;
                    cyc_s   = 1'b1;
                    cti_s   = cti_for(burst_s, beats_s);
                    if (cmd_we) begin
                        state_s = S_WFETCH;
                        stb_s   = 1'b0;
                    end else begin
                        state_s = S_BUS;
                        stb_s   = 1'b1;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end

            S_WFETCH: begin
                if (wr_valid && wr_ready_r) begin
                    dat_s   = wr_data;
                    stb_s   = 1'b1;
                    cti_s   = cti_for(burst_r, beats_r);
                    state_s = S_BUS;
                end else begin
                    stb_s   = 1'b0;
                end
            end

            S_BUS: begin
                if (tmo_hit_s) begin
                    cyc_s   = 1'b0;
                    stb_s   = 1'b0;
                    we_s    = 1'b0;
                    cti_s   = 3'b000;
                    done_s  = 1'b1;
                    err_s   = 1'b1;
                    state_s = S_IDLE;
                end else if (ack_s) begin
                    beats_s = beats_r - 8'd1;
                    addr_s  = addr_r + ADDR_WIDTH'(1);
                    if (!we_r) begin
                        rd_valid_s = 1'b1;
                        rd_data_s  = wb_dat_i;
                    end else begin
                        rd_valid_s = 1'b0;
                    end
                    if (beats_r == 8'd1) begin
                        cyc_s   = 1'b0;
                        stb_s   = 1'b0;
                        we_s    = 1'b0;
                        cti_s   = 3'b000;
                        done_s  = 1'b1;
                        state_s = S_IDLE;
                    end else if (we_r) begin
                        stb_s   = 1'b0;
                        state_s = S_WFETCH;
                    end else begin
                        cti_s   = cti_for(burst_r, beats_r - 8'd1);
                    end
                end else begin
                    state_s = S_BUS;
                end
            end

            default: begin
                cyc_s   = 1'b0;
                stb_s   = 1'b0;
                we_s    = 1'b0;
                state_s = S_IDLE;
            end
        endcase

        // Handshake readies follow the state being entered so they are
        // registered yet line up with that state.
        cmd_ready_s = (state_s == S_IDLE);
        wr_ready_s  = (state_s == S_WFETCH);
    end

    // State and output registers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_r     <= S_IDLE;
            beats_r     <= 8'd0;
            burst_r     <= 1'b0;
            cmd_ready_r <= 1'b0;
            wr_ready_r  <= 1'b0;
            cyc_r       <= 1'b0;
            stb_r       <= 1'b0;
            we_r        <= 1'b0;
            addr_r      <= {ADDR_WIDTH{1'b0}};
            dat_r       <= {DATA_WIDTH{1'b0}};
            sel_r       <= {SEL_WIDTH{1'b0}};
            cti_r       <= 3'b000;
            rd_valid_r  <= 1'b0;
            rd_data_r   <= {DATA_WIDTH{1'b0}};
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            beats_r     <= beats_s;
            burst_r     <= burst_s;
            cmd_ready_r <= cmd_ready_s;
            wr_ready_r  <= wr_ready_s;
            cyc_r       <= cyc_s;
            stb_r       <= stb_s;
            we_r        <= we_s;
            addr_r      <= addr_s;
            dat_r       <= dat_s;
            sel_r       <= sel_s;
            cti_r       <= cti_s;
            rd_valid_r  <= rd_valid_s;
            rd_data_r   <= rd_data_s;
            done_r      <= done_s;
            err_r       <= err_s;
        end
    end

    assign cmd_ready = cmd_ready_r;
    assign wr_ready  = wr_ready_r;
    assign rd_valid  = rd_valid_r;
    assign rd_data   = rd_data_r;
    assign done      = done_r;
    assign err       = err_r;
    assign wb_cyc_o  = cyc_r;
    assign wb_stb_o  = stb_r;
    assign wb_we_o   = we_r;
    assign wb_addr_o = addr_r;
    assign wb_dat_o  = dat_r;
    assign wb_sel_o  = sel_r;
    assign wb_cti_o  = cti_r;

endmodule

// File: tb/tb_wb_burst_master.sv
// -----------------------------------------------------------------------------
// tb_wb_burst_master
//   Directed bench for wb_burst_master. Inputs change and outputs are sampled
//   on the falling clock edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_wb_burst_master;

    localparam int DW = 32;
    localparam int AW = 26;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_we = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [7:0]    cmd_bl = 8'd0;
    logic [3:0]    cmd_sel = 4'h0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] wr_data = '0;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          done;
    logic          err;
    logic          wb_cyc_o;
    logic          wb_stb_o;
    logic          wb_we_o;
    logic [AW-1:0] wb_addr_o;
    logic [DW-1:0] wb_dat_o;
    logic [3:0]    wb_sel_o;
    logic [2:0]    wb_cti_o;
    logic          wb_ack_i = 1'b0;
    logic [DW-1:0] wb_dat_i = '0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    wb_burst_master #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_bl    (cmd_bl),
        .cmd_sel   (cmd_sel),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .done      (done),
        .err       (err),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_we_o   (wb_we_o),
        .wb_addr_o (wb_addr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_sel_o  (wb_sel_o),
        .wb_cti_o  (wb_cti_o),
        .wb_ack_i  (wb_ack_i),
        .wb_dat_i  (wb_dat_i)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Present a command for exactly one accepting rising edge.
    task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [7:0] bl,
                         input logic [3:0] sel);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_bl    = bl;
        cmd_sel   = sel;
        step();
        cmd_valid = 1'b0;
    endtask

    logic [AW-1:0] rd_addr_exp [4];
    logic [2:0]    rd_cti_exp  [4];
    logic [DW-1:0] rd_word     [4];
    logic [DW-1:0] w3_word     [3];
    logic [2:0]    w3_cti      [3];
    int            stb_count;

    initial begin
        rd_addr_exp = '{26'h3FFFFFE, 26'h3FFFFFF, 26'h0000000, 26'h0000001};
        rd_cti_exp  = '{3'b010, 3'b010, 3'b010, 3'b111};
        rd_word     = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
        w3_word     = '{32'hA0A0_0000, 32'hB1B1_1111, 32'hC2C2_2222};
        w3_cti      = '{3'b010, 3'b010, 3'b111};

        // ---- reset state ----
        step();
        step();
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_cyc", wb_cyc_o, 1'b0);
        chk("rst_stb", wb_stb_o, 1'b0);
        chk("rst_wr_ready", wr_ready, 1'b0);
        chk("rst_done_err", {done, err, rd_valid}, 3'b000);
        chk("rst_addr_cti", {wb_addr_o, wb_cti_o}, 29'h0);
        rst_n = 1'b1;
        step();
        chk("cmd_ready_after_rst", cmd_ready, 1'b1);

        // ---- single write 0x100, bl 1 ----
        wr_data = 32'hDEADBEEF;
        issue(1'b1, 26'h100, 8'd1, 4'hA);
        chk("w1_wfetch", {wb_cyc_o, wb_stb_o, wr_ready, cmd_ready}, 4'b1010);
        wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        chk("w1_stb", {wb_cyc_o, wb_stb_o, wb_we_o, wr_ready}, 4'b1110);
        chk("w1_addr", wb_addr_o, 26'h100);
        chk("w1_dat", wb_dat_o, 32'hDEADBEEF);
        chk("w1_sel_cti", {wb_sel_o, wb_cti_o}, {4'hA, 3'b000});
        step();
        chk("w1_stb_hold", {wb_stb_o, wb_addr_o}, {1'b1, 26'h100});
        wb_ack_i = 1'b1;
        step();
        wb_ack_i = 1'b0;
        chk("w1_end", {wb_cyc_o, wb_stb_o, wb_we_o, done, err, cmd_ready}, 6'b000101);
        step();
        chk("w1_done_once", {done, wb_stb_o}, 2'b00);

        // ---- read bl 4 across the address wrap, ack every cycle ----
        issue(1'b0, 26'h3FFFFFE, 8'd4, 4'hF);
        wb_ack_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wb_dat_i = rd_word[i];
            chk($sformatf("r4_addr%0d", i), wb_addr_o, rd_addr_exp[i]);
            chk($sformatf("r4_cti%0d", i), {wb_cyc_o, wb_stb_o, wb_we_o, wb_cti_o},
                {3'b110, rd_cti_exp[i]});
            step();
            chk($sformatf("r4_rd%0d", i), {rd_valid, rd_data}, {1'b1, rd_word[i]});
        end
        wb_ack_i = 1'b0;
        chk("r4_end", {wb_cyc_o, wb_stb_o, done, err}, 4'b0010);
        step();
        chk("r4_quiet", {rd_valid, done}, 2'b00);

        // ---- write bl 3 with a 5-cycle stall before beat 2 ----
        issue(1'b1, 26'h200, 8'd3, 4'h3);
        for (int b = 0; b < 3; b++) begin
            chk($sformatf("w3_wfetch%0d", b), {wb_cyc_o, wb_stb_o, wr_ready}, 3'b101);
            if (b == 1) begin
                for (int s = 0; s < 5; s++) begin
                    step();
                    chk($sformatf("w3_stall%0d", s), {wb_cyc_o, wb_stb_o, wr_ready}, 3'b101);
                end
            end
            wr_valid = 1'b1;
            wr_data  = w3_word[b];
            step();
            wr_valid = 1'b0;
            chk($sformatf("w3_beat%0d", b), {wb_stb_o, wb_we_o, wb_cti_o, wb_sel_o},
                {2'b11, w3_cti[b], 4'h3});
            chk($sformatf("w3_dat%0d", b), {wb_addr_o, wb_dat_o},
                {26'h200 + 26'(b), w3_word[b]});
            wb_ack_i = 1'b1;
            step();
            wb_ack_i = 1'b0;
        end
        chk("w3_end", {wb_cyc_o, wb_stb_o, done, err}, 4'b0010);

        // ---- reset during beat 2 of a read bl 4, then bl 0 read ----
        step();
        issue(1'b0, 26'h10, 8'd4, 4'hF);
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h0BAD_0001;
        step();
        wb_ack_i = 1'b0;
        chk("rr_beat2", {wb_stb_o, wb_addr_o}, {1'b1, 26'h11});
        #2 rst_n = 1'b0;
        #1;
        chk("rr_async_drop", {wb_cyc_o, wb_stb_o, done}, 3'b000);
        step();
        step();
        chk("rr_no_done", {done, err, cmd_ready}, 3'b000);
        rst_n = 1'b1;
        step();
        chk("rr_ready_again", {cmd_ready, done}, 2'b10);

        issue(1'b0, 26'h55, 8'd0, 4'hF);
        chk("bl0_stb", {wb_stb_o, wb_cti_o, wb_addr_o}, {1'b1, 3'b000, 26'h55});
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h5555_AAAA;
        step();
        wb_ack_i = 1'b0;
        chk("bl0_end", {wb_cyc_o, done, err, rd_valid, rd_data}, {4'b0101, 32'h5555_AAAA});
        step();
        chk("bl0_single", {rd_valid, done}, 2'b00);

`ifdef WB_BURST_MASTER_TIMEOUT_EN
        // ---- timeout: ack never returned ----
        issue(1'b0, 26'h40, 8'd2, 4'hF);
        stb_count = 0;
        for (int k = 0; k < 20; k++) begin
            if (wb_stb_o) begin
                stb_count++;
                step();
            end else begin
                break;
            end
        end
        chk("tmo_stb_cycles", stb_count, 8);
        chk("tmo_end", {wb_cyc_o, wb_stb_o, done, err, rd_valid, cmd_ready}, 6'b001101);
        step();
        chk("tmo_pulse", {done, err}, 2'b00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
